// File: rtl/interrupt_controller_if.sv
// Processor-side address/strobe and interrupt handshake of the interrupt controller.
// The shared data bus stays a plain inout net on the controller itself.
interface interrupt_controller_if;
    logic [7:0] addr;
    logic       we;
    logic       int_raise;
    logic       int_ack;

    modport master (output addr, output we, output int_ack, input int_raise);
    modport slave  (input addr, input we, input int_ack, output int_raise);
endinterface

// File: rtl/interrupt_controller.sv
// Eight-source maskable interrupt controller with fixed or round-robin priority,
// a single raise/ack pair to the processor and software end-of-interrupt.
module interrupt_controller #(
    parameter logic [7:0] BASE_ADDR = 8'hE0,
    parameter int         NUM_SRC   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    interrupt_controller_if.slave bus,
    inout  wire  [7:0]            bus_data,
    input  logic [NUM_SRC-1:0]    src_raise,
    output logic [NUM_SRC-1:0]    src_ack
);
    localparam logic [7:0] SRC_BITS = 8'((9'd1 << NUM_SRC) - 9'd1);

    typedef enum logic [1:0] {IDLE, RAISED, SERVICE} state_t;

    state_t             state_q, state_n;
    logic [7:0]         mask_q, pend_q, pend_n;
    logic [1:0]         ctrl_q;
    logic [2:0]         id_q, last_q, winner;
    logic [NUM_SRC-1:0] hist_q, rise_q, ack_n;
    logic               rd_valid_q;
    logic [7:0]         rd_data_q, rd_mux;
    logic               hit, wr_en, rd_en;
    logic [1:0]         off;
    logic [7:0]         wdata, elig;
    logic               any_elig, grant, ack_evt, eoi;

    assign hit      = (bus.addr[7:2] == BASE_ADDR[7:2]);
    assign off      = bus.addr[1:0];
    assign wr_en    = hit & bus.we;
    assign rd_en    = hit & ~bus.we;
    assign wdata    = bus_data;
    assign elig     = pend_q & mask_q & {8{ctrl_q[0]}};
    assign any_elig = |elig;

    // Round-robin scans upward from last_q+1; if nothing is found above, the lowest index wraps in.
    always_comb begin
        logic [2:0] start, win_hi, win_lo;
        logic       hit_hi;
        start  = (ctrl_q[1] && last_q != 3'(NUM_SRC - 1)) ? last_q + 3'd1 : 3'd0;
        win_hi = '0;
        win_lo = '0;
        hit_hi = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (elig[i]) begin
                win_lo = 3'(i);
                if (3'(i) >= start) begin
                    win_hi = 3'(i);
                    hit_hi = 1'b1;
                end
            end
        end
        winner = hit_hi ? win_hi : win_lo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE:    if (any_elig)                                state_n = RAISED;
            RAISED:  if (bus.int_ack)                             state_n = SERVICE;
            SERVICE: if (wr_en && off == 2'd2)                    state_n = IDLE;
            default:                                              state_n = IDLE;
        endcase
    end

    always_comb begin
        grant         = (state_q == IDLE) && any_elig;
        ack_evt       = (state_q == RAISED) && bus.int_ack;
        eoi           = (state_q == SERVICE) && wr_en && (off == 2'd2);
        bus.int_raise = (state_q == RAISED);
    end

    // A new rising edge is OR-ed in last so it beats a same-cycle W1C or ack clear.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        pend_n = pend_q;
        if (wr_en && off == 2'd1) pend_n = pend_n & ~wdata;
        if (ack_evt)              pend_n[id_q] = 1'b0;
        pend_n = pend_n | 8'(rise_q);

        ack_n = '0;
        for (int i = 0; i < NUM_SRC; i++) ack_n[i] = ack_evt && (id_q == 3'(i));
    end

    always_comb begin
        unique case (off)
            2'd0:    rd_mux = mask_q;
            2'd1:    rd_mux = pend_q;
            2'd2:    rd_mux = {(state_q == SERVICE), 4'b0000, id_q};
            default: rd_mux = {6'b000000, ctrl_q};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q     <= '0;
            pend_q     <= '0;
            ctrl_q     <= '0;
            id_q       <= '0;
            last_q     <= 3'(NUM_SRC - 1);
            hist_q     <= '0;
            rise_q     <= '0;
            src_ack    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            hist_q     <= src_raise;
            rise_q     <= src_raise & ~hist_q;
            pend_q     <= pend_n;
            if (wr_en && off == 2'd0) mask_q <= wdata & SRC_BITS;
            if (wr_en && off == 2'd3) ctrl_q <= wdata[1:0];
            if (grant)                id_q   <= winner;
            if (ack_evt)              last_q <= id_q;
            src_ack    <= ack_n;
            rd_valid_q <= rd_en;
            rd_data_q  <= rd_mux;
        end
    end

    assign bus_data = rd_valid_q ? rd_data_q : 8'bz;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: register access, priority modes,
// masking, request withdrawal, set/clear collisions and asynchronous reset.
module tb_interrupt_controller;
    localparam logic [7:0] BASE = 8'hE0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tb_drv;
    logic [7:0] tb_wdata;
    logic [3:0] src_raise, src_ack;
    logic [7:0] rdata;
    logic [3:0] exp_ack;
    int         n_checks = 0;
    int         n_pass   = 0;
    int         rr_ids [4] = '{0, 2, 0, 2};

    interrupt_controller_if bus ();
    tri1 [7:0] bus_data;

    assign bus_data = tb_drv ? tb_wdata : 8'bz;

    interrupt_controller #(.BASE_ADDR(BASE), .NUM_SRC(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .bus_data  (bus_data),
        .src_raise (src_raise),
        .src_ack   (src_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [1:0] off, input logic [7:0] d);
        bus.addr = BASE + 8'(off);
        bus.we   = 1'b1;
        tb_drv   = 1'b1;
        tb_wdata = d;
        tick();
        bus.we   = 1'b0;
        tb_drv   = 1'b0;
        bus.addr = 8'h00;
    endtask

    // Second tick lets the response cycle end before the bench drives the bus again.
    task automatic bus_rd(input logic [1:0] off, output logic [7:0] d);
        bus.addr = BASE + 8'(off);
        bus.we   = 1'b0;
        tick();
        bus.addr = 8'h00;
        d = bus_data;
        tick();
    endtask

    task automatic cpu_ack();
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
    endtask

    task automatic wait_raise(input string tag, input int budget);
        int n = 0;
        while (!bus.int_raise && n < budget) begin
            tick();
            n++;
        end
        check(tag, bus.int_raise, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        bus.addr    = 8'h00;
        bus.we      = 1'b0;
        bus.int_ack = 1'b0;
        tb_drv      = 1'b0;
        tb_wdata    = 8'h00;
        src_raise   = 4'b0000;
        #2;
        check("rst_raise", bus.int_raise, 1'b0);
        check("rst_src_ack", src_ack, 4'b0000);
        check("rst_bus_z", bus_data, 8'hFF);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        bus_rd(2'd0, rdata); check("rst_mask", rdata, 8'h00);
        bus_rd(2'd1, rdata); check("rst_pend", rdata, 8'h00);
        bus_rd(2'd2, rdata); check("rst_status", rdata, 8'h00);
        bus_rd(2'd3, rdata); check("rst_ctrl", rdata, 8'h00);
        bus_wr(2'd0, 8'hFF);
        bus_rd(2'd0, rdata); check("mask_unused_bits", rdata, 8'h0F);

        // Fixed priority: sources 1 and 3 together, 1 wins first.
        bus_wr(2'd3, 8'h01);
        src_raise = 4'b1010;
        tick();
        tick();
        check("fx_raise_n1", bus.int_raise, 1'b0);
        tick();
        check("fx_raise_n2", bus.int_raise, 1'b1);
        bus_rd(2'd2, rdata); check("fx_status_raised", rdata, 8'h01);
        cpu_ack();
        check("fx_raise_after_ack", bus.int_raise, 1'b0);
        check("fx_src_ack1", src_ack, 4'b0010);
        src_raise[1] = 1'b0;
        tick();
        check("fx_src_ack_pulse", src_ack, 4'b0000);
        bus_rd(2'd2, rdata); check("fx_status_service", rdata, 8'h81);
        bus_rd(2'd1, rdata); check("fx_pend_after_ack", rdata, 8'h08);
        bus_wr(2'd2, 8'h00);
        check("fx_eoi_no_raise", bus.int_raise, 1'b0);
        tick();
        check("fx_raise_id3", bus.int_raise, 1'b1);
        bus_rd(2'd2, rdata); check("fx_status_id3", rdata, 8'h03);
        cpu_ack();
        check("fx_src_ack3", src_ack, 4'b1000);
        src_raise[3] = 1'b0;
        bus_wr(2'd2, 8'h00);

        cpu_ack();
        check("ack_idle_src_ack", src_ack, 4'b0000);
        check("ack_idle_raise", bus.int_raise, 1'b0);

        // Masking: pending without a request until the mask opens.
        bus_wr(2'd0, 8'h00);
        src_raise[2] = 1'b1;
        repeat (3) tick();
        check("mk_no_raise", bus.int_raise, 1'b0);
        bus_rd(2'd1, rdata); check("mk_pend", rdata, 8'h04);
        bus_wr(2'd0, 8'h04);
        check("mk_raise_w", bus.int_raise, 1'b0);
        tick();
        check("mk_raise_w1", bus.int_raise, 1'b1);
        bus_rd(2'd2, rdata); check("mk_status", rdata, 8'h02);
        cpu_ack();
        check("mk_src_ack2", src_ack, 4'b0100);
        src_raise[2] = 1'b0;
        bus_wr(2'd2, 8'h00);

        // Withdraw attempt: mask, W1C and EOI while RAISED are all ineffective.
        bus_wr(2'd0, 8'h01);
        src_raise[0] = 1'b1;
        repeat (3) tick();
        check("wd_raise", bus.int_raise, 1'b1);
        bus_wr(2'd0, 8'h00);
        bus_wr(2'd1, 8'h01);
        bus_wr(2'd2, 8'h00);
        tick();
        check("wd_hold", bus.int_raise, 1'b1);
        bus_rd(2'd2, rdata); check("wd_status", rdata, 8'h00);
        cpu_ack();
        check("wd_src_ack0", src_ack, 4'b0001);
        src_raise[0] = 1'b0;
        bus_rd(2'd2, rdata); check("wd_status_service", rdata, 8'h80);
        bus_wr(2'd2, 8'h00);

        // Set edge and W1C on bit 1 in the same cycle: set wins.
        src_raise[1] = 1'b1;
        tick();
        bus_wr(2'd1, 8'h02);
        bus_rd(2'd1, rdata); check("sc_set_wins", rdata, 8'h02);
        bus_wr(2'd1, 8'h02);
        bus_rd(2'd1, rdata); check("sc_w1c", rdata, 8'h00);
        src_raise[1] = 1'b0;

        // Asynchronous reset while RAISED and while the bus is being driven.
        bus_wr(2'd0, 8'h01);
        src_raise[0] = 1'b1;
        repeat (3) tick();
        check("ar_raise", bus.int_raise, 1'b1);
        bus.addr = BASE;
        tick();
        check("ar_bus_driven", bus_data, 8'h01);
        bus.addr = 8'h00;
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_raise_low", bus.int_raise, 1'b0);
        check("ar_bus_z", bus_data, 8'hFF);
        src_raise = 4'b0000;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        bus_rd(2'd0, rdata); check("ar_mask", rdata, 8'h00);
        bus_rd(2'd3, rdata); check("ar_ctrl", rdata, 8'h00);

        // Round-robin: sources 0 and 2 keep re-raising, grants alternate.
        bus_wr(2'd0, 8'h0F);
        bus_wr(2'd3, 8'h03);
        src_raise = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            wait_raise($sformatf("rr_wait%0d", k), 10);
            bus_rd(2'd2, rdata); check($sformatf("rr_id%0d", k), rdata, 8'(rr_ids[k]));
            cpu_ack();
            exp_ack = 4'b0001 << rr_ids[k];
            check($sformatf("rr_ack%0d", k), src_ack, exp_ack);
            src_raise[rr_ids[k]] = 1'b0;
            tick();
            if (k < 2) src_raise[rr_ids[k]] = 1'b1;
            repeat (3) tick();
            bus_wr(2'd2, 8'h00);
        end
        tick();
        check("rr_idle_raise", bus.int_raise, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
